// File: rtl/autosel_uart_pkg.sv
// Shared types and constants for the autosel UART receive path.
package autosel_uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int BIT_CNT_W      = $clog2(UART_DATA_BITS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // Serial data arrives LSB first, so each new bit enters at the MSB end.
  function automatic logic [UART_DATA_BITS-1:0] shift_lsb_first(
      input logic [UART_DATA_BITS-1:0] sh,
      input logic                      bit_in
  );
    return {bit_in, sh[UART_DATA_BITS-1:1]};
  endfunction

endpackage

// File: rtl/autosel_uart_rx_if.sv
// Valid/ready byte stream from the UART receiver to the selector control logic.
interface autosel_uart_rx_if;
  import autosel_uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_ready;

  modport master (output rx_data, output rx_valid, input  rx_ready);
  modport slave  (input  rx_data, input  rx_valid, output rx_ready);

endinterface

// File: rtl/autosel_rx_fifo.sv
// Small receive FIFO: occupancy counter plus wrapping read/write pointers.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module autosel_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == (AW+1)'(0));
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/autosel_uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, bit-period divider, framing FSM
// and a small receive FIFO drained over a valid/ready interface.
module autosel_uart_rx
  import autosel_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DIV_W        = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_i,
  autosel_uart_rx_if.master         rx_bus,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      busy
);

  localparam logic [DIV_W-1:0]     C_BIT_LAST  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [DIV_W-1:0]     C_HALF_LAST = DIV_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_CNT_W-1:0] C_IDX_LAST  = BIT_CNT_W'(UART_DATA_BITS - 1);

  logic                      r_sync1;
  logic                      r_sync2;
  logic                      w_rxs;

  rx_state_t                 r_state;
  rx_state_t                 w_state_nxt;
  logic [DIV_W-1:0]          r_cnt;
  logic [DIV_W-1:0]          w_cnt_nxt;
  logic [BIT_CNT_W-1:0]      r_bit_idx;
  logic [BIT_CNT_W-1:0]      w_bit_idx_nxt;
  logic [UART_DATA_BITS-1:0] r_shreg;
  logic [UART_DATA_BITS-1:0] w_shreg_nxt;
  logic                      w_push;
  logic                      w_stop_low;

  logic                      r_frame_err;
  logic                      r_overrun;
  logic                      r_busy;

  logic [UART_DATA_BITS-1:0] w_fifo_dout;
  logic                      w_fifo_empty;
  logic                      w_fifo_full;
  logic                      w_drop;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  // Framing FSM state plus divider, bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shreg   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shreg   <= w_shreg_nxt;
    end
  end

  // Next-state logic; the start bit is re-checked at mid-bit to reject glitches.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shreg_nxt   = r_shreg;
    w_push        = 1'b0;
    w_stop_low    = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rxs) begin
          w_state_nxt = START;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (r_cnt == C_HALF_LAST) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
          if (w_rxs) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DATA;
          end
        end else begin
          w_cnt_nxt = r_cnt + DIV_W'(1);
        end
      end
      DATA: begin
        if (r_cnt == C_BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_shreg_nxt = shift_lsb_first(r_shreg, w_rxs);
          if (r_bit_idx == C_IDX_LAST) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + BIT_CNT_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + DIV_W'(1);
        end
      end
      STOP: begin
        if (r_cnt == C_BIT_LAST) begin
          w_cnt_nxt = '0;
          if (w_rxs) begin
            w_push      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_stop_low  = 1'b1;
            w_state_nxt = BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt + DIV_W'(1);
        end
      end
      BREAK: begin
        // A line held low must return high before another start is accepted.
        w_cnt_nxt = '0;
        if (w_rxs) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = BREAK;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  autosel_rx_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (w_shreg_nxt),
    .pop   (rx_bus.rx_ready),
    .dout  (w_fifo_dout),
    .empty (w_fifo_empty),
    .full  (w_fifo_full)
  );

  // A same-cycle pop frees a slot, so only a push into a full, non-draining FIFO is lost.
  assign w_drop = w_push && w_fifo_full && !rx_bus.rx_ready;

  // Registered status pulses and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_frame_err <= w_stop_low;
      r_overrun   <= w_drop;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign frame_err       = r_frame_err;
  assign overrun         = r_overrun;
  assign busy            = r_busy;
  assign rx_bus.rx_valid = !w_fifo_empty;
  assign rx_bus.rx_data  = w_fifo_dout;

endmodule

// File: tb/tb_autosel_uart_rx.sv
// Directed bench for autosel_uart_rx at 16 clocks per bit; stimulus on falling
// edges, observation 1 time unit after each falling edge.
module tb_autosel_uart_rx;

  localparam int CPB = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx_i  = 1'b1;
  logic frame_err;
  logic overrun;
  logic busy;

  autosel_uart_rx_if u_bus ();

  autosel_uart_rx #(
    .CLKS_PER_BIT (CPB),
    .DIV_W        (16),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_i      (rx_i),
    .rx_bus    (u_bus.master),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  int       ferr_cnt      = 0;
  int       ovr_cnt       = 0;
  int       busy_cnt      = 0;
  int       valid_cnt     = 0;
  int       pop_n         = 0;
  int       last_valid_cyc = 0;
  logic [7:0] popped [0:63];

  int b_pop, b_ferr, b_ovr, b_busy, b_valid, start_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe DUT outputs away from the rising edge.
  always @(negedge clk) begin
    #1;
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (busy) busy_cnt++;
    if (u_bus.rx_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end
    if (u_bus.rx_valid && u_bus.rx_ready && pop_n < 64) begin
      popped[pop_n] = u_bus.rx_data;
      pop_n++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx_i = stop_b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic snap();
    b_pop   = pop_n;
    b_ferr  = ferr_cnt;
    b_ovr   = ovr_cnt;
    b_busy  = busy_cnt;
    b_valid = valid_cnt;
  endtask

  initial begin
    u_bus.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_valid", 32'(u_bus.rx_valid), 32'd0);
    check_eq("rst_data", 32'(u_bus.rx_data), 32'h00);
    check_eq("rst_ferr", 32'(frame_err), 32'd0);
    check_eq("rst_ovr", 32'(overrun), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte with consumer always ready.
    u_bus.rx_ready = 1'b1;
    snap();
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    check_eq("single_pops", 32'(pop_n - b_pop), 32'd1);
    check_eq("single_data", 32'(popped[b_pop]), 32'hA5);
    check_eq("single_vcyc", 32'(valid_cnt - b_valid), 32'd1);
    check_eq("single_lat", 32'(last_valid_cyc - start_cyc), 32'd155);
    check_eq("single_ferr", 32'(ferr_cnt - b_ferr), 32'd0);
    check_eq("single_busy", 32'(busy), 32'd0);

    // Back-to-back frames held in the FIFO.
    u_bus.rx_ready = 1'b0;
    snap();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    check_eq("b2b_valid", 32'(u_bus.rx_valid), 32'd1);
    check_eq("b2b_head", 32'(u_bus.rx_data), 32'h00);
    repeat (10) @(negedge clk);
    check_eq("b2b_hold", 32'(u_bus.rx_data), 32'h00);
    check_eq("b2b_ovr", 32'(ovr_cnt - b_ovr), 32'd0);
    u_bus.rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    u_bus.rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("b2b_pops", 32'(pop_n - b_pop), 32'd3);
    check_eq("b2b_d0", 32'(popped[b_pop]), 32'h00);
    check_eq("b2b_d1", 32'(popped[b_pop+1]), 32'hFF);
    check_eq("b2b_d2", 32'(popped[b_pop+2]), 32'h3C);
    check_eq("b2b_empty", 32'(u_bus.rx_valid), 32'd0);

    // Short low glitch: false start only.
    snap();
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    rx_i = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("glitch_busy_cyc", 32'(busy_cnt - b_busy), 32'd8);
    check_eq("glitch_valid", 32'(valid_cnt - b_valid), 32'd0);
    check_eq("glitch_ferr", 32'(ferr_cnt - b_ferr), 32'd0);
    check_eq("glitch_busy", 32'(busy), 32'd0);

    // Framing error followed by a held-low line, then a good byte.
    u_bus.rx_ready = 1'b1;
    snap();
    send_frame(8'h55, 1'b0);
    repeat (40) @(negedge clk);
    rx_i = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("frm_ferr", 32'(ferr_cnt - b_ferr), 32'd1);
    check_eq("frm_valid", 32'(valid_cnt - b_valid), 32'd0);
    check_eq("frm_busy", 32'(busy), 32'd0);
    send_frame(8'h12, 1'b1);
    repeat (20) @(negedge clk);
    check_eq("frm_next_pops", 32'(pop_n - b_pop), 32'd1);
    check_eq("frm_next_data", 32'(popped[b_pop]), 32'h12);
    check_eq("frm_ferr_once", 32'(ferr_cnt - b_ferr), 32'd1);

    // Overrun: fifth byte dropped.
    u_bus.rx_ready = 1'b0;
    snap();
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
    repeat (20) @(negedge clk);
    check_eq("ovr_cnt", 32'(ovr_cnt - b_ovr), 32'd1);
    check_eq("ovr_ferr", 32'(ferr_cnt - b_ferr), 32'd0);
    u_bus.rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    u_bus.rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("ovr_pops", 32'(pop_n - b_pop), 32'd4);
    for (int k = 0; k < 4; k++) check_eq("ovr_drain", 32'(popped[b_pop+k]), 32'(k + 1));
    check_eq("ovr_empty", 32'(u_bus.rx_valid), 32'd0);

    // Same traffic, but a pop coincides with the fifth push.
    snap();
    for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1);
    fork
      send_frame(8'h05, 1'b1);
      begin
        repeat (154) @(negedge clk);
        u_bus.rx_ready = 1'b1;
        @(negedge clk);
        u_bus.rx_ready = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    check_eq("nov_cnt", 32'(ovr_cnt - b_ovr), 32'd0);
    u_bus.rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    u_bus.rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("nov_pops", 32'(pop_n - b_pop), 32'd5);
    for (int k = 0; k < 5; k++) check_eq("nov_drain", 32'(popped[b_pop+k]), 32'(k + 1));
    check_eq("nov_empty", 32'(u_bus.rx_valid), 32'd0);

    // Reset mid-byte with a stale byte still queued.
    snap();
    send_frame(8'h99, 1'b1);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_i = 1'(8'hC3 >> i);
      repeat (CPB) @(negedge clk);
    end
    rx_i = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("mid_busy_pre", 32'(busy), 32'd1);
    check_eq("mid_valid_pre", 32'(u_bus.rx_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_valid", 32'(u_bus.rx_valid), 32'd0);
    check_eq("mid_rst_data", 32'(u_bus.rx_data), 32'h00);
    check_eq("mid_rst_ferr", 32'(frame_err), 32'd0);
    check_eq("mid_rst_ovr", 32'(overrun), 32'd0);
    rx_i = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("post_busy", 32'(busy), 32'd0);
    check_eq("post_valid", 32'(u_bus.rx_valid), 32'd0);
    snap();
    u_bus.rx_ready = 1'b1;
    send_frame(8'h7E, 1'b1);
    repeat (20) @(negedge clk);
    check_eq("post_pops", 32'(pop_n - b_pop), 32'd1);
    check_eq("post_data", 32'(popped[b_pop]), 32'h7E);
    check_eq("post_ferr", 32'(ferr_cnt - b_ferr), 32'd0);
    check_eq("post_ovr", 32'(ovr_cnt - b_ovr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
